tcb_cmd_man: RTL and testbench

- TCB manager (initiator) that turns a valid/ready command stream into TCB transfers and returns one response per command on a valid/ready response stream.
- Used by test harnesses and simple controllers to drive TCB subordinates such as the GPIO and UART register blocks.
- Fixed TCB response delay DLY=1: read data and error are sampled one cycle after the transfer cycle.
- Credit-based response FIFO, so responses are never lost under response backpressure.

---
 rtl/tcb_cmd_man.sv | 146 ++++++++++++++
 tb/tb_tcb_cmd_man.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcb_cmd_man.sv
// TCB manager: valid/ready commands in, TCB transfers out (DLY=1), in-order responses back.
// Optional rdy-wait abort is enabled by defining TCB_CMD_MAN_TIMEOUT_EN.
module tcb_cmd_man #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_vld,
    output logic          cmd_rdy,
    input  logic          cmd_wen,
    input  logic [AW-1:0] cmd_adr,
    input  logic [DW-1:0] cmd_wdt,
    output logic          tcb_vld,
    input  logic          tcb_rdy,
    output logic          tcb_wen,
    output logic [AW-1:0] tcb_adr,
    output logic [DW-1:0] tcb_wdt,
    input  logic [DW-1:0] tcb_rdt,
    input  logic          tcb_err,
    output logic          rsp_vld,
    input  logic          rsp_rdy,
    output logic          rsp_wen,
    output logic [DW-1:0] rsp_rdt,
    output logic          rsp_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CREDITS = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [IW:0]   PTR_ONE = (IW + 1)'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("tcb_cmd_man: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    logic          req_full;
    logic          req_wen;
    logic [AW-1:0] req_adr;
    logic [DW-1:0] req_wdt;
    logic [CW-1:0] cnt;
    logic          xfer;
    logic          abort;
    logic          take;
    logic          pop;
    logic          cap_vld;
    logic          cap_wen;
    logic          cap_abt;
    logic [DW+1:0] cap_dat;
    logic [IW:0]   wptr;
    logic [IW:0]   rptr;
    logic [DW+1:0] mem [DEPTH];

    // A credit is held from transfer until pop, so the FIFO can always absorb the capture.
    assign tcb_vld = req_full && (cnt < CREDITS);
    assign xfer    = tcb_vld && tcb_rdy;
    assign take    = xfer || abort;
    assign cmd_rdy = !rst && (!req_full || xfer);
    assign tcb_wen = req_wen;
    assign tcb_adr = req_adr;
    assign tcb_wdt = req_wdt;

    assign rsp_vld = (wptr != rptr);
    assign pop     = rsp_vld && rsp_rdy;
    assign {rsp_wen, rsp_rdt, rsp_err} = mem[rptr[IW-1:0]];
    assign cap_dat = {cap_wen, (cap_wen || cap_abt) ? {DW{1'b0}} : tcb_rdt, tcb_err || cap_abt};

`ifdef TCB_CMD_MAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic [TW-1:0] tmo_cnt;

    // Abort on the TIMEOUT-th waiting cycle; rdy=1 on that cycle still wins as a transfer.
    assign abort = tcb_vld && !tcb_rdy && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst || take) begin
            tmo_cnt <= '0;
        end else if (tcb_vld) begin
            tmo_cnt <= tmo_cnt + TMO_ONE;
        end
    end
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            req_full <= 1'b0;
            req_wen  <= 1'b0;
            req_adr  <= '0;
            req_wdt  <= '0;
        end else if (cmd_vld && cmd_rdy) begin
            req_full <= 1'b1;
            req_wen  <= cmd_wen;
            req_adr  <= cmd_adr;
            req_wdt  <= cmd_wdt;
        end else if (take) begin
            req_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (take && !pop) begin
            cnt <= cnt + CNT_ONE;
        end else if (pop && !take) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    // Read data and error arrive one cycle after the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld <= 1'b0;
            cap_wen <= 1'b0;
            cap_abt <= 1'b0;
        end else begin
            cap_vld <= take;
            cap_wen <= req_wen;
            cap_abt <= abort;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (cap_vld) wptr <= wptr + PTR_ONE;
            if (pop)     rptr <= rptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (cap_vld) mem[wptr[IW-1:0]] <= cap_dat;
    end

endmodule

// File: tb/tb_tcb_cmd_man.sv
// Self-checking bench for tcb_cmd_man: queue-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_tcb_cmd_man;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic          wen;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdt;
    } cmd_t;

    typedef struct {
        logic          wen;
        logic [DW-1:0] rdt;
        logic          err;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic          cmd_wen;
    logic [AW-1:0] cmd_adr;
    logic [DW-1:0] cmd_wdt;
    logic          tcb_vld;
    logic          tcb_rdy;
    logic          tcb_wen;
    logic [AW-1:0] tcb_adr;
    logic [DW-1:0] tcb_wdt;
    logic [DW-1:0] tcb_rdt;
    logic          tcb_err;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic          rsp_wen;
    logic [DW-1:0] rsp_rdt;
    logic          rsp_err;

    tcb_cmd_man #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wen(cmd_wen), .cmd_adr(cmd_adr), .cmd_wdt(cmd_wdt),
        .tcb_vld(tcb_vld), .tcb_rdy(tcb_rdy), .tcb_wen(tcb_wen), .tcb_adr(tcb_adr), .tcb_wdt(tcb_wdt),
        .tcb_rdt(tcb_rdt), .tcb_err(tcb_err),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_wen(rsp_wen), .rsp_rdt(rsp_rdt), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int   n_pass;
    int   n_chk;

    // Reference model state
    cmd_t req_q[$];
    rsp_t rsp_q[$];
    int   out_cnt;
    bit   cap_pending;
    bit   cap_wen;
    bit   last_hs;
    bit   dut_hs;
    bit   dut_xfer;
    bit   dut_pop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_idle();
        rst     = 1'b0;
        cmd_vld = 1'b0;
        cmd_wen = 1'b0;
        cmd_adr = '0;
        cmd_wdt = '0;
        tcb_rdy = 1'b1;
        tcb_rdt = 32'hDEAD_BEEF;
        tcb_err = 1'b0;
        rsp_rdy = 1'b1;
    endtask

    // Called at a negedge with inputs already set: compare, advance the model, move to next negedge.
    task automatic cycle();
        bit exp_tvld, exp_xfer, exp_crdy, exp_rvld, exp_pop;
        #1;
        exp_tvld = (req_q.size() != 0) && (out_cnt < DEPTH);
        exp_xfer = exp_tvld && tcb_rdy;
        exp_crdy = !rst && ((req_q.size() == 0) || exp_xfer);
        exp_rvld = (rsp_q.size() != 0);
        exp_pop  = exp_rvld && rsp_rdy;
        check("cmd_rdy", cmd_rdy, exp_crdy);
        if (!rst) begin
            check("tcb_vld", tcb_vld, exp_tvld);
            if (exp_tvld) begin
                check("tcb_wen", tcb_wen, req_q[0].wen);
                check("tcb_adr", tcb_adr, req_q[0].adr);
                check("tcb_wdt", tcb_wdt, req_q[0].wdt);
            end
            check("rsp_vld", rsp_vld, exp_rvld);
            if (exp_rvld) begin
                check("rsp_wen", rsp_wen, rsp_q[0].wen);
                check("rsp_rdt", rsp_rdt, rsp_q[0].rdt);
                check("rsp_err", rsp_err, rsp_q[0].err);
            end
            check("credits", dut.cnt, out_cnt);
        end
        dut_hs   = cmd_vld && cmd_rdy;
        dut_xfer = tcb_vld && tcb_rdy;
        dut_pop  = rsp_vld && rsp_rdy;
        last_hs  = cmd_vld && exp_crdy;
        if (rst) begin
            req_q.delete();
            rsp_q.delete();
            out_cnt     = 0;
            cap_pending = 1'b0;
        end else begin
            if (exp_pop) void'(rsp_q.pop_front());
            if (cap_pending) rsp_q.push_back('{cap_wen, cap_wen ? 32'h0 : tcb_rdt, tcb_err});
            cap_pending = exp_xfer;
            if (exp_xfer) begin
                cap_wen = req_q[0].wen;
                void'(req_q.pop_front());
            end
            if (last_hs) req_q.push_back('{cmd_wen, cmd_adr, cmd_wdt});
            out_cnt += int'(exp_xfer) - int'(exp_pop);
        end
        @(negedge clk);
    endtask

    initial begin
        int tv_cnt, tv_first, tv_last, rv_cnt, rv_first, rv_last;
        int hs, nx, np, rv;
        int rsp_p, rdy_p;

        n_pass = 0; n_chk = 0; out_cnt = 0; cap_pending = 1'b0; cap_wen = 1'b0;
        last_hs = 1'b0; dut_hs = 1'b0; dut_xfer = 1'b0; dut_pop = 1'b0;
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        repeat (3) cycle();
        rst = 1'b0;
        #1;
        check("rst_tcb_vld", tcb_vld, 1'b0);
        check("rst_rsp_vld", rsp_vld, 1'b0);
        check("rst_tcb_wen", tcb_wen, 1'b0);
        check("rst_tcb_adr", tcb_adr, 32'h0);
        check("rst_tcb_wdt", tcb_wdt, 32'h0);
        check("rst_cmd_rdy", cmd_rdy, 1'b1);

        // Single write: tcb_vld one cycle after handshake, response at xfer+2
        cmd_vld = 1'b1; cmd_wen = 1'b1; cmd_adr = 32'h0; cmd_wdt = 32'hA5;
        cycle();
        cmd_vld = 1'b0;
        check("t1_tcb_vld", tcb_vld, 1'b1);
        check("t1_tcb_wen", tcb_wen, 1'b1);
        check("t1_tcb_adr", tcb_adr, 32'h0);
        check("t1_tcb_wdt", tcb_wdt, 32'hA5);
        cycle();
        check("t1_rsp_early", rsp_vld, 1'b0);
        cycle();
        check("t1_rsp_vld", rsp_vld, 1'b1);
        check("t1_rsp_wen", rsp_wen, 1'b1);
        check("t1_rsp_rdt", rsp_rdt, 32'h0);
        check("t1_rsp_err", rsp_err, 1'b0);
        cycle();

        // Reads: data and error sampled one cycle after the transfer
        cmd_vld = 1'b1; cmd_wen = 1'b0; cmd_adr = 32'h8;
        cycle();
        cmd_vld = 1'b0;
        check("t2_tcb_adr", tcb_adr, 32'h8);
        check("t2_tcb_wen", tcb_wen, 1'b0);
        cycle();
        tcb_rdt = 32'h1234_5678; tcb_err = 1'b0;
        cycle();
        tcb_rdt = 32'hDEAD_BEEF;
        check("t2_rsp_rdt", rsp_rdt, 32'h1234_5678);
        check("t2_rsp_wen", rsp_wen, 1'b0);
        check("t2_rsp_err", rsp_err, 1'b0);
        cycle();
        cmd_vld = 1'b1; cmd_adr = 32'hC;
        cycle();
        cmd_vld = 1'b0;
        cycle();
        tcb_rdt = 32'h0BAD_0BAD; tcb_err = 1'b1;
        cycle();
        tcb_rdt = 32'hDEAD_BEEF; tcb_err = 1'b0;
        check("t2_err_rsp_err", rsp_err, 1'b1);
        check("t2_err_rsp_rdt", rsp_rdt, 32'h0BAD_0BAD);
        cycle();

        // Eight back-to-back reads
        tv_cnt = 0; tv_first = 0; tv_last = 0; rv_cnt = 0; rv_first = 0; rv_last = 0;
        for (int i = 0; i < 14; i++) begin
            cmd_vld = (i < 8); cmd_wen = 1'b0; cmd_adr = 32'h100 + 32'(i * 4);
            tcb_rdt = $urandom;
            cycle();
            if (tcb_vld) begin
                if (tv_cnt == 0) tv_first = i;
                tv_last = i; tv_cnt++;
            end
            if (rsp_vld) begin
                if (rv_cnt == 0) rv_first = i;
                rv_last = i; rv_cnt++;
            end
        end
        check("t3_xfers", tv_cnt, 8);
        check("t3_xfer_span", tv_last - tv_first + 1, 8);
        check("t3_rsps", rv_cnt, 8);
        check("t3_rsp_span", rv_last - rv_first + 1, 8);

        // Response backpressure: DEPTH transfers, then stall
        rsp_rdy = 1'b0; hs = 0; nx = 0;
        for (int i = 0; i < 16; i++) begin
            cmd_vld = (hs < 6); cmd_wen = 1'b0; cmd_adr = 32'h200 + 32'(hs * 4);
            tcb_rdt = $urandom;
            cycle();
            if (dut_hs) hs++;
            if (dut_xfer) nx++;
        end
        #1;
        check("t4_handshakes", hs, 5);
        check("t4_xfers", nx, DEPTH);
        check("t4_tcb_vld_stall", tcb_vld, 1'b0);
        check("t4_cmd_rdy_stall", cmd_rdy, 1'b0);
        rsp_rdy = 1'b1; np = 0;
        for (int i = 0; i < 20; i++) begin
            cmd_vld = (hs < 6); cmd_adr = 32'h200 + 32'(hs * 4);
            tcb_rdt = $urandom;
            cycle();
            if (dut_hs) hs++;
            if (dut_pop) np++;
        end
        check("t4_pops", np, 6);
        check("t4_cnt_zero", dut.cnt, 0);

        // tcb_rdy low for three cycles: request held stable
        cmd_vld = 1'b1; cmd_wen = 1'b1; cmd_adr = 32'h300; cmd_wdt = 32'h5A5A; tcb_rdy = 1'b0;
        cycle();
        cmd_vld = 1'b0; nx = 0;
        for (int i = 0; i < 4; i++) begin
            tcb_rdy = (i == 3);
            #1;
            check("t5_hold_vld", tcb_vld, 1'b1);
            check("t5_hold_adr", tcb_adr, 32'h300);
            check("t5_hold_wdt", tcb_wdt, 32'h5A5A);
            cycle();
            if (dut_xfer) nx++;
        end
        check("t5_one_xfer", nx, 1);
        check("t5_vld_after", tcb_vld, 1'b0);
        repeat (3) cycle();

        // Reset with a response in flight and a request queued
        cmd_vld = 1'b1; cmd_wen = 1'b0; cmd_adr = 32'h400;
        cycle();
        cmd_adr = 32'h404;
        cycle();
        cmd_vld = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("t5_rst_tcb_vld", tcb_vld, 1'b0);
        check("t5_rst_rsp_vld", rsp_vld, 1'b0);
        check("t5_rst_tcb_adr", tcb_adr, 32'h0);
        check("t5_rst_cmd_rdy", cmd_rdy, 1'b1);
        rv = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (rsp_vld || tcb_vld) rv++;
        end
        check("t5_no_stale", rv, 0);

        // Randomized traffic with varying backpressure and occasional reset
        rsp_p = 4; rdy_p = 4;
        for (int i = 0; i < 2500; i++) begin
            if (i % 250 == 0) begin
                rsp_p = $urandom_range(0, 4);
                rdy_p = $urandom_range(1, 4);
            end
            if (!cmd_vld || last_hs || rst) begin
                cmd_vld = ($urandom_range(0, 3) != 0);
                cmd_wen = 1'($urandom_range(0, 1));
                cmd_adr = $urandom;
                cmd_wdt = $urandom;
            end
            tcb_rdy = ($urandom_range(0, 4) < rdy_p);
            rsp_rdy = ($urandom_range(0, 4) < rsp_p);
            tcb_rdt = $urandom;
            tcb_err = ($urandom_range(0, 7) == 0);
            rst     = ($urandom_range(0, 399) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
